// File: rtl/hit_event_pkg.sv
// hit_event_pkg
// Shared types and defaults for the hit event manager.
// It holds:
//   - the game state enum, which also drives the state output port
//   - default point and frame values
//   - widths for lives, level and the frame timers
package hit_event_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAY       = 3'd1,
    LEVEL_DONE = 3'd2,
    GAME_OVER  = 3'd3,
    WIN        = 3'd4
  } state_e;

  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 3;
  localparam int TIMER_W = 8;

  localparam int DEF_INIT_LIVES    = 3;
  localparam int DEF_SCORE_W       = 16;
  localparam int DEF_BONUS_POINTS  = 100;
  localparam int DEF_LEVEL_POINTS  = 500;
  localparam int DEF_INVULN_FRAMES = 60;
  localparam int DEF_BLINK_FRAMES  = 4;
  localparam int DEF_PAUSE_FRAMES  = 90;
  localparam int DEF_MAX_LEVEL     = 4;

endpackage

// File: rtl/frame_timer.sv
// frame_timer
// Loadable down counter that counts frames (one step per tick).
// Ports:
//   clk, resetN  - clock, asynchronous active-low reset
//   load         - load load_value and start counting; wins over clear and tick
//   load_value   - frames to count
//   tick         - frame pulse (startOfFrame)
//   clear        - stop the timer without expiring
//   count        - remaining frames
//   expired      - combinational pulse on the tick that runs the timer out
//                  (a load of 0 expires on the first tick)
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         tick,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic         active_q;

  // Expiry is flagged on the tick itself so the owner can react in the same
  // cycle and still present a registered result one clock later.
  assign expired = tick & active_q & ~load & ~clear & (count_q <= W'(1));
  assign count   = count_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      count_q  <= load_value;
      active_q <= 1'b1;
    end else if (clear) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (tick && active_q) begin
      if (count_q <= W'(1)) begin
        count_q  <= '0;
        active_q <= 1'b0;
      end else begin
        count_q <= count_q - W'(1);
      end
    end
  end

endmodule

// File: rtl/hit_event_manager.sv
// hit_event_manager
// Turns the collision controller's single-hit pulses into game state:
//   - lives, saturating score and level
//   - post-hit invulnerability with sprite blink
//   - level-complete pause, game over and win
// Ports:
//   clk, resetN                  - clock, asynchronous active-low reset
//   startOfFrame                 - frame pulse driving every timer
//   start_game                   - start / restart key pulse
//   hit_barrel, hit_fire         - damage hits
//   hit_bonus                    - bonus points hit
//   hit_goal                     - level goal reached
//   state                        - current state
//   lives, score, level          - HUD values
//   freeze                       - movers hold position
//   kong_visible                 - sprite enable (blinks while invulnerable)
//   level_up                     - one-cycle pulse on level completion
//   game_over                    - high in GAME_OVER and WIN
// All outputs are registered.
module hit_event_manager
  import hit_event_pkg::*;
#(
  parameter int INIT_LIVES    = DEF_INIT_LIVES,
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int BONUS_POINTS  = DEF_BONUS_POINTS,
  parameter int LEVEL_POINTS  = DEF_LEVEL_POINTS,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES,
  parameter int PAUSE_FRAMES  = DEF_PAUSE_FRAMES,
  parameter int MAX_LEVEL     = DEF_MAX_LEVEL
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               start_game,
  input  logic               hit_barrel,
  input  logic               hit_fire,
  input  logic               hit_bonus,
  input  logic               hit_goal,
  output state_e             state,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level,
  output logic               freeze,
  output logic               kong_visible,
  output logic               level_up,
  output logic               game_over
);

  localparam logic [TIMER_W-1:0] InvLoad   = TIMER_W'(INVULN_FRAMES);
  localparam logic [TIMER_W-1:0] PauseLoad = TIMER_W'(PAUSE_FRAMES);
  localparam logic [LIVES_W-1:0] InitLives = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0] OneLife   = LIVES_W'(1);
  localparam logic [LEVEL_W-1:0] MaxLevel  = LEVEL_W'(MAX_LEVEL);
  localparam logic [7:0]         BlinkLast = 8'(BLINK_FRAMES - 1);
  localparam logic [SCORE_W:0]   BonusAdd  = (SCORE_W + 1)'(BONUS_POINTS);
  localparam logic [SCORE_W:0]   LevelAdd  = (SCORE_W + 1)'(LEVEL_POINTS);

  state_e             state_q;
  logic [LIVES_W-1:0] lives_q;
  logic [SCORE_W-1:0] score_q;
  logic [LEVEL_W-1:0] level_q;
  logic               freeze_q;
  logic               kongVisible_q;
  logic               levelUp_q;
  logic               gameOver_q;
  logic               invuln_q;
  logic [7:0]         blinkCnt_q;

  logic               inPlay;
  logic               damage;
  logic               invLoad;
  logic               pauseLoad;
  logic               invExpired;
  logic               pauseExpired;
  logic [TIMER_W-1:0] invCount;
  logic [TIMER_W-1:0] pauseCount;
  logic               unusedCounts;
  logic [SCORE_W:0]   scoreSum_d;
  logic [SCORE_W-1:0] score_d;

  assign inPlay = (state_q == PLAY);
  assign damage = hit_barrel | hit_fire;

  // A goal shadows damage, and a damage hit on the last life ends the game
  // instead of starting invulnerability.
  assign invLoad   = inPlay & ~hit_goal & damage & ~invuln_q & (lives_q != OneLife);
  assign pauseLoad = inPlay & hit_goal & (level_q != MaxLevel);

  // Timer counts are only needed by HUD/debug consumers, not by this block.
  assign unusedCounts = ^{invCount, pauseCount};

  // One extra bit catches the carry so the score pins at all-ones.
  assign scoreSum_d = {1'b0, score_q}
                    + (hit_bonus ? BonusAdd : '0)
                    + (hit_goal  ? LevelAdd : '0);
  assign score_d    = scoreSum_d[SCORE_W] ? '1 : scoreSum_d[SCORE_W-1:0];

  frame_timer #(.W(TIMER_W)) invTimer (
    .clk        (clk),
    .resetN     (resetN),
    .load       (invLoad),
    .load_value (InvLoad),
    .tick       (startOfFrame),
    .clear      (~inPlay),
    .count      (invCount),
    .expired    (invExpired)
  );

  frame_timer #(.W(TIMER_W)) pauseTimer (
    .clk        (clk),
    .resetN     (resetN),
    .load       (pauseLoad),
    .load_value (PauseLoad),
    .tick       (startOfFrame),
    .clear      (state_q != LEVEL_DONE),
    .count      (pauseCount),
    .expired    (pauseExpired)
  );

  // Game FSM with every output registered alongside the state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      lives_q       <= '0;
      score_q       <= '0;
      level_q       <= LEVEL_W'(1);
      freeze_q      <= 1'b1;
      kongVisible_q <= 1'b1;
      levelUp_q     <= 1'b0;
      gameOver_q    <= 1'b0;
      invuln_q      <= 1'b0;
      blinkCnt_q    <= '0;
    end else begin
      levelUp_q <= 1'b0;
      case (state_q)
        IDLE, GAME_OVER, WIN: begin
          if (start_game) begin
            state_q       <= PLAY;
            lives_q       <= InitLives;
            score_q       <= '0;
            level_q       <= LEVEL_W'(1);
            freeze_q      <= 1'b0;
            gameOver_q    <= 1'b0;
            kongVisible_q <= 1'b1;
            invuln_q      <= 1'b0;
            blinkCnt_q    <= '0;
          end
        end
        PLAY: begin
          score_q <= score_d;
          if (hit_goal) begin
            levelUp_q     <= 1'b1;
            freeze_q      <= 1'b1;
            kongVisible_q <= 1'b1;
            invuln_q      <= 1'b0;
            if (level_q == MaxLevel) begin
              state_q    <= WIN;
              gameOver_q <= 1'b1;
            end else begin
              state_q <= LEVEL_DONE;
            end
          end else if (damage && !invuln_q) begin
            if (lives_q == OneLife) begin
              lives_q       <= '0;
              state_q       <= GAME_OVER;
              freeze_q      <= 1'b1;
              gameOver_q    <= 1'b1;
              kongVisible_q <= 1'b1;
            end else begin
              lives_q    <= lives_q - OneLife;
              invuln_q   <= 1'b1;
              blinkCnt_q <= '0;
            end
          end else if (invuln_q) begin
            if (invExpired) begin
              invuln_q      <= 1'b0;
              kongVisible_q <= 1'b1;
            end else if (startOfFrame) begin
              if (blinkCnt_q == BlinkLast) begin
                blinkCnt_q    <= '0;
                kongVisible_q <= ~kongVisible_q;
              end else begin
                blinkCnt_q <= blinkCnt_q + 8'd1;
              end
            end
          end
        end
        LEVEL_DONE: begin
          if (pauseExpired) begin
            state_q  <= PLAY;
            level_q  <= level_q + LEVEL_W'(1);
            freeze_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign lives        = lives_q;
  assign score        = score_q;
  assign level        = level_q;
  assign freeze       = freeze_q;
  assign kong_visible = kongVisible_q;
  assign level_up     = levelUp_q;
  assign game_over    = gameOver_q;

endmodule

// File: tb/tb_hit_event_manager.sv
// tb_hit_event_manager
// Directed scenarios plus a randomized run, checked against a frame-level
// model of the game rules kept in this bench.
module tb_hit_event_manager;
  import hit_event_pkg::*;

  localparam int P_LIVES  = 3;
  localparam int P_BONUS  = 100;
  localparam int P_LEVEL  = 500;
  localparam int P_INV    = 60;
  localparam int P_BLINK  = 4;
  localparam int P_PAUSE  = 90;
  localparam int P_MAXLVL = 4;
  localparam int P_SMAX   = 65535;

  localparam int S_IDLE = 0, S_PLAY = 1, S_LD = 2, S_GO = 3, S_WIN = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        start_game = 1'b0;
  logic        hit_barrel = 1'b0;
  logic        hit_fire = 1'b0;
  logic        hit_bonus = 1'b0;
  logic        hit_goal = 1'b0;
  state_e      state;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [2:0]  level;
  logic        freeze;
  logic        kong_visible;
  logic        level_up;
  logic        game_over;
  logic [2:0]  stateBits;

  int nCompared = 0;
  int nMismatched = 0;

  int mState, mLives, mScore, mLevel, mInvLeft, mFrames, mPause;
  bit mInvul, mLevelUp;

  assign stateBits = state;

  hit_event_manager dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .start_game   (start_game),
    .hit_barrel   (hit_barrel),
    .hit_fire     (hit_fire),
    .hit_bonus    (hit_bonus),
    .hit_goal     (hit_goal),
    .state        (state),
    .lives        (lives),
    .score        (score),
    .level        (level),
    .freeze       (freeze),
    .kong_visible (kong_visible),
    .level_up     (level_up),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  // Reference model: game rules applied once per clock to the sampled inputs.
  task automatic modelReset();
    mState = S_IDLE; mLives = 0; mScore = 0; mLevel = 1;
    mInvul = 0; mInvLeft = 0; mFrames = 0; mPause = 0; mLevelUp = 0;
  endtask

  task automatic modelStart();
    mState = S_PLAY; mLives = P_LIVES; mScore = 0; mLevel = 1;
    mInvul = 0; mInvLeft = 0; mFrames = 0;
  endtask

  task automatic modelStep(input bit sof, input bit st, input bit b, input bit f,
                           input bit bn, input bit g);
    mLevelUp = 0;
    case (mState)
      S_IDLE, S_GO, S_WIN: if (st) modelStart();
      S_PLAY: begin
        mScore = mScore + (bn ? P_BONUS : 0) + (g ? P_LEVEL : 0);
        if (mScore > P_SMAX) mScore = P_SMAX;
        if (g) begin
          mLevelUp = 1;
          mInvul = 0;
          if (mLevel == P_MAXLVL) mState = S_WIN;
          else begin mState = S_LD; mPause = P_PAUSE; end
        end else if ((b || f) && !mInvul) begin
          if (mLives == 1) begin mLives = 0; mState = S_GO; end
          else begin mLives--; mInvul = 1; mInvLeft = P_INV; mFrames = 0; end
        end else if (mInvul && sof) begin
          mFrames++;
          mInvLeft--;
          if (mInvLeft == 0) mInvul = 0;
        end
      end
      S_LD: if (sof) begin
        mPause--;
        if (mPause == 0) begin mState = S_PLAY; mLevel++; end
      end
      default: ;
    endcase
  endtask

  function automatic logic [28:0] modelVec();
    bit kong;
    kong = (mState == S_PLAY && mInvul) ? (((mFrames / P_BLINK) % 2) == 0) : 1'b1;
    return {3'(mState), 3'(mLives), 16'(mScore), 3'(mLevel),
            1'(mState != S_PLAY), kong, mLevelUp,
            1'(mState == S_GO || mState == S_WIN)};
  endfunction

  task automatic cycle(input bit sof, input bit st, input bit b, input bit f,
                       input bit bn, input bit g);
    @(negedge clk);
    startOfFrame = sof; start_game = st; hit_barrel = b;
    hit_fire = f; hit_bonus = bn; hit_goal = g;
    @(posedge clk);
    modelStep(sof, st, b, f, bn, g);
    #1;
    startOfFrame = 0; start_game = 0; hit_barrel = 0;
    hit_fire = 0; hit_bonus = 0; hit_goal = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    resetN = 0;
    modelReset();
    #2;
    @(negedge clk);
    resetN = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetN = 0;
    modelReset();
    #1;
    nCompared++;
    if ({stateBits, lives, score, level, freeze, kong_visible, level_up, game_over}
        !== {3'd0, 3'd0, 16'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL reset_values: got st=%0d lv=%0d sc=%0d lvl=%0d fr=%b kv=%b lu=%b go=%b want 0/0/0/1/1/1/0/0",
               stateBits, lives, score, level, freeze, kong_visible, level_up, game_over);
    end
    @(negedge clk);
    resetN = 1;
  endtask

  task automatic test_start();
    cycle(0, 1, 0, 0, 0, 0);
    nCompared++;
    if ({stateBits, lives, score, level, freeze} !== {3'd1, 3'd3, 16'd0, 3'd1, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL start_init: got st=%0d lv=%0d sc=%0d lvl=%0d fr=%b want 1/3/0/1/0",
               stateBits, lives, score, level, freeze);
    end
  endtask

  task automatic test_damage_invuln();
    bit wantKong;
    doReset();
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    nCompared++;
    if (lives !== 3'd2) begin
      nMismatched++;
      $display("[TB] FAIL dual_damage_lives: got %0d want 2", lives);
    end
    for (int i = 1; i <= P_INV; i++) begin
      cycle(1, 0, 0, (i == 11), 0, 0);
      wantKong = (i >= P_INV) ? 1'b1 : (((i / P_BLINK) % 2) == 0);
      nCompared++;
      if (kong_visible !== wantKong) begin
        nMismatched++;
        $display("[TB] FAIL blink_frame%0d: got %b want %b", i, kong_visible, wantKong);
      end
      if (i == 11) begin
        nCompared++;
        if (lives !== 3'd2) begin
          nMismatched++;
          $display("[TB] FAIL invuln_ignore: got %0d want 2", lives);
        end
      end
    end
    cycle(0, 0, 1, 0, 0, 0);
    nCompared++;
    if (lives !== 3'd1) begin
      nMismatched++;
      $display("[TB] FAIL hit_after_invuln: got %0d want 1", lives);
    end
  endtask

  task automatic test_game_over();
    doReset();
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    for (int h = 0; h < 3; h++) begin
      cycle(0, 0, 1, 0, 0, 0);
      nCompared++;
      if (lives !== 3'(2 - h)) begin
        nMismatched++;
        $display("[TB] FAIL go_hit%0d_lives: got %0d want %0d", h, lives, 2 - h);
      end
      for (int k = 0; k < 61; k++) cycle(1, 0, 0, 0, 0, 0);
    end
    nCompared++;
    if ({stateBits, game_over, freeze} !== {3'd3, 1'b1, 1'b1}) begin
      nMismatched++;
      $display("[TB] FAIL game_over_state: got st=%0d go=%b fr=%b want 3/1/1",
               stateBits, game_over, freeze);
    end
    cycle(0, 0, 0, 0, 1, 0);
    nCompared++;
    if (score !== 16'd100) begin
      nMismatched++;
      $display("[TB] FAIL go_bonus_ignored: got %0d want 100", score);
    end
    cycle(0, 1, 0, 0, 0, 0);
    nCompared++;
    if ({stateBits, lives, score, game_over} !== {3'd1, 3'd3, 16'd0, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL restart: got st=%0d lv=%0d sc=%0d go=%b want 1/3/0/0",
               stateBits, lives, score, game_over);
    end
  endtask

  task automatic test_goal();
    doReset();
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 1, 1);
    nCompared++;
    if ({score, lives, level_up, stateBits, freeze} !== {16'd600, 3'd3, 1'b1, 3'd2, 1'b1}) begin
      nMismatched++;
      $display("[TB] FAIL goal_combo: got sc=%0d lv=%0d lu=%b st=%0d fr=%b want 600/3/1/2/1",
               score, lives, level_up, stateBits, freeze);
    end
    cycle(0, 0, 0, 0, 0, 0);
    nCompared++;
    if (level_up !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL level_up_pulse: got %b want 0", level_up);
    end
    for (int k = 1; k < P_PAUSE; k++) cycle(1, 0, 0, 0, 0, 0);
    nCompared++;
    if (stateBits !== 3'd2) begin
      nMismatched++;
      $display("[TB] FAIL pause_89: got st=%0d want 2", stateBits);
    end
    cycle(1, 0, 0, 0, 0, 0);
    nCompared++;
    if ({stateBits, level, freeze} !== {3'd1, 3'd2, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL pause_end: got st=%0d lvl=%0d fr=%b want 1/2/0", stateBits, level, freeze);
    end
  endtask

  task automatic test_saturate();
    doReset();
    cycle(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 655; k++) cycle(0, 0, 0, 0, 1, 0);
    nCompared++;
    if (score !== 16'd65500) begin
      nMismatched++;
      $display("[TB] FAIL preload: got %0d want 65500", score);
    end
    cycle(0, 0, 0, 0, 1, 0);
    nCompared++;
    if (score !== 16'd65535) begin
      nMismatched++;
      $display("[TB] FAIL saturate: got %0d want 65535", score);
    end
    cycle(0, 0, 0, 0, 1, 0);
    nCompared++;
    if (score !== 16'd65535) begin
      nMismatched++;
      $display("[TB] FAIL saturate_hold: got %0d want 65535", score);
    end
  endtask

  task automatic test_win_reset();
    doReset();
    cycle(0, 1, 0, 0, 0, 0);
    for (int l = 1; l < P_MAXLVL; l++) begin
      cycle(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < P_PAUSE; k++) cycle(1, 0, 0, 0, 0, 0);
      nCompared++;
      if (level !== 3'(l + 1)) begin
        nMismatched++;
        $display("[TB] FAIL level_advance%0d: got %0d want %0d", l, level, l + 1);
      end
    end
    cycle(0, 0, 0, 0, 0, 1);
    nCompared++;
    if ({stateBits, game_over, level_up, score} !== {3'd4, 1'b1, 1'b1, 16'd2000}) begin
      nMismatched++;
      $display("[TB] FAIL win: got st=%0d go=%b lu=%b sc=%0d want 4/1/1/2000",
               stateBits, game_over, level_up, score);
    end
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) cycle(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    resetN = 0;
    modelReset();
    #1;
    nCompared++;
    if ({stateBits, lives, score, level, freeze, game_over} !== {3'd0, 3'd0, 16'd0, 3'd1, 1'b1, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL async_reset_mid_pause: got st=%0d lv=%0d sc=%0d lvl=%0d fr=%b go=%b want 0/0/0/1/1/0",
               stateBits, lives, score, level, freeze, game_over);
    end
    @(negedge clk);
    resetN = 1;
  endtask

  task automatic test_random();
    logic [28:0] got, want;
    bit sof, st, b, f, bn, g;
    doReset();
    for (int n = 0; n < 3000; n++) begin
      sof = ($urandom_range(1, 0) == 0);
      st  = ($urandom_range(39, 0) == 0);
      b   = ($urandom_range(24, 0) == 0);
      f   = ($urandom_range(24, 0) == 0);
      bn  = ($urandom_range(9, 0) == 0);
      g   = ($urandom_range(119, 0) == 0);
      cycle(sof, st, b, f, bn, g);
      got  = {stateBits, lives, score, level, freeze, kong_visible, level_up, game_over};
      want = modelVec();
      nCompared++;
      if (got !== want) begin
        nMismatched++;
        $display("[TB] FAIL random_cycle%0d: got %h want %h", n, got, want);
      end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_start();
    test_damage_invuln();
    test_game_over();
    test_goal();
    test_saturate();
    test_win_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
